// File: rtl/rv_pkg.sv
// Shared RV32I/RV64I decode definitions: opcodes, funct7 values, immediate formats
// and the per-instruction control-flag bundle.
package rv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_MEM    = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  localparam logic [6:0] FUN7_BASE = 7'b0000000;
  localparam logic [6:0] FUN7_ALT  = 7'b0100000;
  // RV64 shifts use a 6-bit shamt, so only instr[31:26] carries the funct field
  localparam logic [5:0] FUN6_BASE = 6'b000000;
  localparam logic [5:0] FUN6_ALT  = 6'b010000;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  typedef struct packed {
    logic reg_write;
    logic use_rs1;
    logic use_rs2;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jump;
    logic is_sys;
    logic word_op;
    logic illegal;
  } ctl_t;

endpackage

// File: rtl/rv_imm_gen.sv
// Immediate generator: builds the sign-extended XLEN immediate for an instruction format.
// Latency: purely combinational.
// Backpressure: none, no state.
module rv_imm_gen
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  // Upper bits are filled with the sign first, then the low field is overlaid,
  // which works unchanged for both XLEN=32 and XLEN=64.
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: begin
        imm        = {XLEN{instr[31]}};
        imm[11:0]  = instr[31:20];
      end
      FMT_S: begin
        imm        = {XLEN{instr[31]}};
        imm[11:0]  = {instr[31:25], instr[11:7]};
      end
      FMT_B: begin
        imm        = {XLEN{instr[31]}};
        imm[12:0]  = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      FMT_U: begin
        imm        = {XLEN{instr[31]}};
        imm[31:0]  = {instr[31:12], 12'b0};
      end
      FMT_J: begin
        imm        = {XLEN{instr[31]}};
        imm[20:0]  = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/rv_decode_stage.sv
// RV32I/RV64I decode pipeline stage; DECODE_SKID_EN adds a one-entry skid buffer.
// Latency: 1 cycle from accept to out_valid, one instruction per cycle.
// Backpressure: in_ready = !flush && (!out_valid || out_ready); with skid, in_ready = !skid_full (registered).
module rv_decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_fun3,
  output logic [6:0]      out_fun7,
  output logic [XLEN-1:0] out_imm,
  output logic            out_reg_write,
  output logic            out_use_rs1,
  output logic            out_use_rs2,
  output logic            out_is_load,
  output logic            out_is_store,
  output logic            out_is_branch,
  output logic            out_is_jump,
  output logic            out_is_sys,
  output logic            out_word_op,
  output logic            out_illegal
);

  localparam bit RV64 = (XLEN == 64);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    ctl_t            ctl;
  } bundle_t;

  logic [6:0]      op;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic            known;
  logic            bad;
  logic            writes;
  logic            rtype_bad;
  imm_fmt_e        fmt;
  ctl_t            ctl;
  logic [XLEN-1:0] imm;
  bundle_t         in_b;
  bundle_t         out_q;
  logic            accept;

  assign op = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];

  assign rtype_bad = ((f7 != FUN7_BASE) && (f7 != FUN7_ALT)) ||
                     ((f7 == FUN7_ALT) && (f3 != 3'b000) && (f3 != 3'b101));

  always_comb begin
    fmt    = FMT_NONE;
    ctl    = '0;
    known  = 1'b1;
    bad    = 1'b0;
    writes = 1'b0;
    case (op)
      OP_LUI, OP_AUIPC: begin
        fmt    = FMT_U;
        writes = 1'b1;
      end
      OP_JAL: begin
        fmt         = FMT_J;
        writes      = 1'b1;
        ctl.is_jump = 1'b1;
      end
      OP_JALR: begin
        fmt         = FMT_I;
        writes      = 1'b1;
        ctl.is_jump = 1'b1;
        ctl.use_rs1 = 1'b1;
      end
      OP_BRANCH: begin
        fmt           = FMT_B;
        ctl.is_branch = 1'b1;
        ctl.use_rs1   = 1'b1;
        ctl.use_rs2   = 1'b1;
        bad           = (f3[2:1] == 2'b01);
      end
      OP_LOAD: begin
        fmt         = FMT_I;
        writes      = 1'b1;
        ctl.is_load = 1'b1;
        ctl.use_rs1 = 1'b1;
        bad         = (f3 == 3'b111) || (!RV64 && (f3 == 3'b011));
      end
      OP_STORE: begin
        fmt          = FMT_S;
        ctl.is_store = 1'b1;
        ctl.use_rs1  = 1'b1;
        ctl.use_rs2  = 1'b1;
        bad          = RV64 ? (f3 >= 3'b100) : (f3 >= 3'b011);
      end
      OP_IMM: begin
        fmt         = FMT_I;
        writes      = 1'b1;
        ctl.use_rs1 = 1'b1;
        if ((f3 == 3'b001) || (f3 == 3'b101)) begin
          bad = RV64 ? !((in_instr[31:26] == FUN6_BASE) || (in_instr[31:26] == FUN6_ALT))
                     : !((f7 == FUN7_BASE) || (f7 == FUN7_ALT));
        end
      end
      OP_IMM_32: begin
        if (RV64) begin
          fmt         = FMT_I;
          writes      = 1'b1;
          ctl.use_rs1 = 1'b1;
          ctl.word_op = 1'b1;
        end else begin
          known = 1'b0;
        end
      end
      OP_OP: begin
        writes      = 1'b1;
        ctl.use_rs1 = 1'b1;
        ctl.use_rs2 = 1'b1;
        bad         = rtype_bad;
      end
      OP_32: begin
        if (RV64) begin
          writes      = 1'b1;
          ctl.use_rs1 = 1'b1;
          ctl.use_rs2 = 1'b1;
          ctl.word_op = 1'b1;
          bad         = rtype_bad;
        end else begin
          known = 1'b0;
        end
      end
      OP_MEM, OP_SYS: ctl.is_sys = 1'b1;
      default: known = 1'b0;
    endcase

    ctl.illegal   = !known || bad || (in_instr[1:0] != 2'b11);
    ctl.reg_write = writes && (in_instr[11:7] != 5'd0);
    // Illegal words travel down the pipe but must not trigger any side effects
    if (ctl.illegal) begin
      ctl         = '0;
      ctl.illegal = 1'b1;
    end
  end

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr),
    .fmt   (fmt),
    .imm   (imm)
  );

  assign in_b   = '{pc: in_pc, instr: in_instr, imm: imm, ctl: ctl};
  assign accept = in_valid && in_ready;

`ifdef DECODE_SKID_EN
  bundle_t skid_q;
  logic    skid_full;

  assign in_ready = !skid_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      skid_full <= 1'b0;
      skid_q    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_full <= 1'b0;
    end else if (!out_valid || out_ready) begin
      // Output slot frees up: older skid entry goes first
      if (skid_full) begin
        out_q     <= skid_q;
        out_valid <= 1'b1;
        skid_full <= 1'b0;
      end else if (accept) begin
        out_q     <= in_b;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q    <= in_b;
      skid_full <= 1'b1;
    end
  end
`else
  assign in_ready = !flush && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_q     <= in_b;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

  assign out_pc        = out_q.pc;
  assign out_opcode    = out_q.instr[6:0];
  assign out_rd        = out_q.instr[11:7];
  assign out_rs1       = out_q.instr[19:15];
  assign out_rs2       = out_q.instr[24:20];
  assign out_fun3      = out_q.instr[14:12];
  assign out_fun7      = out_q.instr[31:25];
  assign out_imm       = out_q.imm;
  assign out_reg_write = out_q.ctl.reg_write;
  assign out_use_rs1   = out_q.ctl.use_rs1;
  assign out_use_rs2   = out_q.ctl.use_rs2;
  assign out_is_load   = out_q.ctl.is_load;
  assign out_is_store  = out_q.ctl.is_store;
  assign out_is_branch = out_q.ctl.is_branch;
  assign out_is_jump   = out_q.ctl.is_jump;
  assign out_is_sys    = out_q.ctl.is_sys;
  assign out_word_op   = out_q.ctl.word_op;
  assign out_illegal   = out_q.ctl.illegal;

endmodule
